// File: rtl/rpi_readout_port_pkg.sv
// Constants and types shared by the FIFO readout port and the write-side framer.
// An event is TUBE_COUNT tube words followed by a single STOP_WORD terminator.
package readout_pkg;

  localparam int DATA_W          = 16;
  localparam int TUBE_COUNT      = 32;
  localparam int WORDS_PER_EVENT = TUBE_COUNT + 1;

  localparam logic [DATA_W-1:0] STOP_WORD = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rd_state_t;

  // Tube words carry the tube name in the low byte, which is never 0xFF,
  // so only the terminator can match this.
  function automatic logic is_stop_word(input logic [DATA_W-1:0] w);
    return (w == STOP_WORD);
  endfunction

endpackage

// File: rtl/rpi_readout_port_if.sv
// Read side of the event FIFO: pop strobe out, empty/valid/data back.
// master = readout port, slave = FIFO.
interface rpi_readout_port_if #(
  parameter int DATA_W = 16
) ();

  logic              fifo_empty;
  logic              fifo_valid;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_rd_en;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_valid,
    input  fifo_dout
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_valid,
    output fifo_dout
  );

endinterface

// File: rtl/rpi_readout_port_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous strobe plus a one-cycle
// rising-edge pulse in the destination clock domain.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/rpi_readout_port.sv
// Raspberry Pi readout port: pops one FIFO word per RD_CLK rising edge, holds it
// on otube with rd_valid, and checks event framing (tube words + stop word).
module rpi_readout_port
  import readout_pkg::*;
#(
  parameter int                SYNC_STAGES     = 2,
  parameter int                WORDS_PER_EVENT = readout_pkg::WORDS_PER_EVENT,
  parameter logic [DATA_W-1:0] STOP_WORD       = readout_pkg::STOP_WORD,
  parameter int                RD_TIMEOUT      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rd_clk_pi,
  input  logic                      rd_en_pi,
  rpi_readout_port_if.master        fifo,
  output logic [DATA_W-1:0]         otube,
  output logic                      rd_valid,
  output logic                      rd_empty,
  output logic [15:0]               event_count,
  output logic                      frame_err,
  output logic                      underflow_err
);

  localparam int IDX_W = $clog2(WORDS_PER_EVENT);
  localparam int TMR_W = $clog2(RD_TIMEOUT + 1);

  logic                   rd_rise;
  logic [SYNC_STAGES-1:0] en_sync_q;
  logic                   en_sync;

  rd_state_t              state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   pop_d;
  logic                   fifo_rd_en_q;
  logic                   clr_valid;
  logic                   accept;
  logic                   timeout;

  logic [IDX_W-1:0]       word_idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   evt_done;
  logic                   frm_err_nxt;

  // Wrong-position stop and missing stop both resync the index to zero;
  // exactly one of "last slot" and "stop word" being true is a framing error.
  function automatic void frame_step(
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] w,
    output logic [IDX_W-1:0]  idx_n,
    output logic              done,
    output logic              err
  );
    logic last;
    logic stop;
    last  = (idx == IDX_W'(WORDS_PER_EVENT - 1));
    stop  = (w == STOP_WORD);
    idx_n = (last || stop) ? '0 : idx + IDX_W'(1);
    done  = last & stop;
    err   = last ^ stop;
  endfunction

  // Strobe resynchronisation
  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rd_clk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rd_clk_pi),
    .rise     (rd_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sync_q <= '0;
    end else begin
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], rd_en_pi};
    end
  end

  assign en_sync = en_sync_q[SYNC_STAGES-1];

  // Pop / wait-for-data control
  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pop_d     = 1'b0;
    clr_valid = 1'b0;
    accept    = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (rd_rise) begin
          clr_valid = 1'b1;
          // The raw empty flag is used so that empty rising together with the
          // strobe suppresses the pop.
          if (en_sync && !fifo.fifo_empty) begin
            pop_d   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (fifo.fifo_valid) begin
          accept  = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == TMR_W'(RD_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_nxt     = '0;
    evt_done    = 1'b0;
    frm_err_nxt = 1'b0;
    frame_step(word_idx, fifo.fifo_dout, idx_nxt, evt_done, frm_err_nxt);
  end

  // Registered outputs and framing state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      fifo_rd_en_q  <= 1'b0;
      rd_valid      <= 1'b0;
      rd_empty      <= 1'b1;
      otube         <= '0;
      word_idx      <= '0;
      event_count   <= '0;
      frame_err     <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      fifo_rd_en_q <= pop_d;
      rd_empty     <= fifo.fifo_empty;
      if (accept) begin
        otube    <= fifo.fifo_dout;
        rd_valid <= 1'b1;
        word_idx <= idx_nxt;
        if (evt_done) begin
          event_count <= event_count + 16'd1;
        end
        if (frm_err_nxt) begin
          frame_err <= 1'b1;
        end
      end else if (clr_valid) begin
        rd_valid <= 1'b0;
      end
      if (timeout) begin
        underflow_err <= 1'b1;
      end
    end
  end

  assign fifo.fifo_rd_en = fifo_rd_en_q;

endmodule

// File: tb/tb_rpi_readout_port.sv
// Bench for rpi_readout_port: FIFO model with 1-cycle read latency, RPi strobe
// driver, table-driven vectors, corner-case sequences and a random framing run.
module tb_rpi_readout_port;

  logic        clk;
  logic        rst_n;
  logic        rd_clk_pi;
  logic        rd_en_pi;
  logic [15:0] otube;
  logic        rd_valid;
  logic        rd_empty;
  logic [15:0] event_count;
  logic        frame_err;
  logic        underflow_err;

  rpi_readout_port_if #(.DATA_W(16)) ifc ();

  rpi_readout_port dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_clk_pi     (rd_clk_pi),
    .rd_en_pi      (rd_en_pi),
    .fifo          (ifc.master),
    .otube         (otube),
    .rd_valid      (rd_valid),
    .rd_empty      (rd_empty),
    .event_count   (event_count),
    .frame_err     (frame_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pops   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // FIFO model: a pop seen in one cycle returns data with valid in the next
  logic [15:0] fq[$];
  logic        pend  = 1'b0;
  logic        stall = 1'b0;
  logic        prev_rd_en = 1'b0;

  always @(negedge clk) begin
    if (ifc.fifo_rd_en === 1'b1) begin
      pops++;
      chk("pop_single_cycle", {31'd0, prev_rd_en}, 32'd0);
    end
    prev_rd_en = ifc.fifo_rd_en;
    pend       = ifc.fifo_rd_en;
  end

  initial begin
    ifc.fifo_valid = 1'b0;
    ifc.fifo_dout  = 16'h0000;
    ifc.fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.fifo_valid = 1'b0;
      if (pend && !stall && fq.size() > 0) begin
        ifc.fifo_dout  = fq.pop_front();
        ifc.fifo_valid = 1'b1;
      end
      ifc.fifo_empty = (fq.size() == 0);
    end
  end

  // Reference model of what the RPi should observe
  logic [15:0] m_q[$];
  int          m_idx;
  logic [15:0] m_count;
  logic        m_ferr;
  logic [15:0] m_otube;
  logic        m_valid;

  task automatic model_reset();
    m_q.delete();
    m_idx   = 0;
    m_count = 16'd0;
    m_ferr  = 1'b0;
    m_otube = 16'h0000;
    m_valid = 1'b0;
  endtask

  // An event is complete only when the stop word lands in slot 32; any other
  // stop position, or a non-stop word in slot 32, is an error and restarts.
  task automatic model_accept(input logic [15:0] w);
    m_otube = w;
    m_valid = 1'b1;
    if (m_idx == 32) begin
      if (w == 16'hFFFF) m_count = m_count + 16'd1;
      else               m_ferr  = 1'b1;
      m_idx = 0;
    end else if (w == 16'hFFFF) begin
      m_ferr = 1'b1;
      m_idx  = 0;
    end else begin
      m_idx = m_idx + 1;
    end
  endtask

  function automatic logic [15:0] tube_word();
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'($urandom_range(0, 255));
    lo = 8'($urandom_range(0, 254));
    return {hi, lo};
  endfunction

  task automatic reset_dut();
    rst_n     = 1'b0;
    stall     = 1'b0;
    rd_clk_pi = 1'b0;
    rd_en_pi  = 1'b0;
    fq.delete();
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One complete RPi strobe; returns at a negedge well after the result settles
  task automatic rpi_read(input logic en);
    repeat (2) @(posedge clk);
    #2;
    rd_en_pi  = en;
    rd_clk_pi = 1'b1;
    repeat (4) @(posedge clk);
    #2 rd_clk_pi = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input string tag, input logic en, input logic have, input logic [15:0] w);
    int p0;
    logic exp_pop;
    if (have) begin
      fq.push_back(w);
      m_q.push_back(w);
    end
    p0 = pops;
    rpi_read(en);
    exp_pop = en && (m_q.size() > 0);
    if (exp_pop) model_accept(m_q.pop_front());
    else         m_valid = 1'b0;
    chk({tag, "_pops"},  32'(pops - p0), {31'd0, exp_pop});
    chk({tag, "_otube"}, {16'd0, otube}, {16'd0, m_otube});
    chk({tag, "_valid"}, {31'd0, rd_valid}, {31'd0, m_valid});
    chk({tag, "_empty"}, {31'd0, rd_empty}, {31'd0, (m_q.size() == 0)});
    chk({tag, "_count"}, {16'd0, event_count}, {16'd0, m_count});
    chk({tag, "_ferr"},  {31'd0, frame_err}, {31'd0, m_ferr});
  endtask

  task automatic feed_event(input string tag);
    for (int i = 0; i < 33; i++) begin
      do_read(tag, 1'b1, 1'b1, (i == 32) ? 16'hFFFF : tube_word());
    end
  endtask

  typedef struct {
    logic        en;
    logic        push;
    logic [15:0] word;
    int          exp_pops;
    logic        exp_valid;
    logic [15:0] exp_otube;
    logic        exp_empty;
    logic        exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    int gen_idx;
    logic [15:0] w;

    tbl[0] = '{1'b1, 1'b1, 16'h2A03, 1, 1'b1, 16'h2A03, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0000, 0, 1'b0, 16'h2A03, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h1234, 0, 1'b0, 16'h2A03, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 16'h0000, 1, 1'b1, 16'h1234, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 16'h0501, 1, 1'b1, 16'h0501, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'hFFFF, 1, 1'b1, 16'hFFFF, 1'b1, 1'b1};

    rst_n     = 1'b0;
    rd_clk_pi = 1'b0;
    rd_en_pi  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en",     {31'd0, ifc.fifo_rd_en}, 32'd0);
    chk("rst_otube",     {16'd0, otube}, 32'd0);
    chk("rst_valid",     {31'd0, rd_valid}, 32'd0);
    chk("rst_empty",     {31'd0, rd_empty}, 32'd1);
    chk("rst_count",     {16'd0, event_count}, 32'd0);
    chk("rst_ferr",      {31'd0, frame_err}, 32'd0);
    chk("rst_underflow", {31'd0, underflow_err}, 32'd0);
    #2 rst_n = 1'b1;

    // First-word latency: result must appear SYNC_STAGES+3 cycles after the edge
    fq.push_back(16'h2A03);
    repeat (2) @(posedge clk);
    #2;
    rd_en_pi  = 1'b1;
    rd_clk_pi = 1'b1;
    p0 = pops;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lat_not_yet_valid", {31'd0, rd_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", {31'd0, rd_valid}, 32'd1);
    chk("lat_otube", {16'd0, otube}, 32'h2A03);
    chk("lat_pops",  32'(pops - p0), 32'd1);
    rd_clk_pi = 1'b0;
    repeat (6) @(posedge clk);

    // Table-driven single reads
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].push) fq.push_back(tbl[i].word);
      p0 = pops;
      rpi_read(tbl[i].en);
      chk($sformatf("tbl%0d_pops", i),  32'(pops - p0), 32'(tbl[i].exp_pops));
      chk($sformatf("tbl%0d_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_otube", i), {16'd0, otube}, {16'd0, tbl[i].exp_otube});
      chk($sformatf("tbl%0d_empty", i), {31'd0, rd_empty}, {31'd0, tbl[i].exp_empty});
      chk($sformatf("tbl%0d_ferr", i),  {31'd0, frame_err}, {31'd0, tbl[i].exp_ferr});
    end

    // One clean event, then a second to confirm the index returned to zero
    reset_dut();
    p0 = pops;
    feed_event("ev1");
    chk("ev1_total_pops", 32'(pops - p0), 32'd33);
    chk("ev1_count", {16'd0, event_count}, 32'd1);
    feed_event("ev2");
    chk("ev2_count", {16'd0, event_count}, 32'd2);
    chk("ev2_ferr",  {31'd0, frame_err}, 32'd0);

    // Early stop word at index 10, then a full event still counts
    reset_dut();
    for (int i = 0; i < 10; i++) do_read("early", 1'b1, 1'b1, tube_word());
    do_read("early_stop", 1'b1, 1'b1, 16'hFFFF);
    chk("early_ferr", {31'd0, frame_err}, 32'd1);
    feed_event("after_early");
    chk("after_early_count", {16'd0, event_count}, 32'd1);
    chk("after_early_ferr",  {31'd0, frame_err}, 32'd1);

    // Underflow: pop issued but the FIFO never returns data
    reset_dut();
    fq.push_back(16'h1111);
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rd_en_pi  = 1'b1;
    rd_clk_pi = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("uf_not_yet", {31'd0, underflow_err}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("uf_set",   {31'd0, underflow_err}, 32'd1);
    chk("uf_valid", {31'd0, rd_valid}, 32'd0);
    rd_clk_pi = 1'b0;
    stall     = 1'b0;
    repeat (4) @(posedge clk);
    p0 = pops;
    rpi_read(1'b1);
    chk("uf_next_pops",  32'(pops - p0), 32'd1);
    chk("uf_next_otube", {16'd0, otube}, 32'h1111);
    chk("uf_next_valid", {31'd0, rd_valid}, 32'd1);
    chk("uf_sticky",     {31'd0, underflow_err}, 32'd1);

    // Asynchronous reset while waiting for data, after five events
    reset_dut();
    for (int e = 0; e < 5; e++) feed_event("five");
    chk("five_count", {16'd0, event_count}, 32'd5);
    chk("five_valid", {31'd0, rd_valid}, 32'd1);
    fq.push_back(16'h0707);
    stall = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rd_clk_pi = 1'b1;
    p0 = pops;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wait_popped", 32'(pops - p0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rd_en",     {31'd0, ifc.fifo_rd_en}, 32'd0);
    chk("arst_otube",     {16'd0, otube}, 32'd0);
    chk("arst_valid",     {31'd0, rd_valid}, 32'd0);
    chk("arst_empty",     {31'd0, rd_empty}, 32'd1);
    chk("arst_count",     {16'd0, event_count}, 32'd0);
    chk("arst_ferr",      {31'd0, frame_err}, 32'd0);
    chk("arst_underflow", {31'd0, underflow_err}, 32'd0);

    // Random strobes, enables, empty reads and occasional framing faults
    reset_dut();
    gen_idx = 0;
    for (int n = 0; n < 200; n++) begin
      logic en;
      logic have;
      en   = ($urandom_range(0, 7) != 0);
      have = ($urandom_range(0, 9) != 0);
      w    = 16'h0000;
      if (have) begin
        if (gen_idx == 32) w = ($urandom_range(0, 9) == 0) ? tube_word() : 16'hFFFF;
        else               w = ($urandom_range(0, 49) == 0) ? 16'hFFFF : tube_word();
        gen_idx = (gen_idx == 32 || w == 16'hFFFF) ? 0 : gen_idx + 1;
      end
      do_read("rnd", en, have, w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
